// File: rtl/joy_serial_pkg.sv
// Shared types and constants for the DB9/JAMMA serial joystick reader.
// No logic; the frame-period helper gives the cycle count between commits.
package joy_serial_pkg;

  localparam int DEF_CLK_DIV   = 8;
  localparam int DEF_NUM_BITS  = 16;
  localparam int DEF_GAP_TICKS = 64;

  typedef enum logic [1:0] {
    ST_GAP      = 2'd0,
    ST_LOAD     = 2'd1,
    ST_SHIFT_LO = 2'd2,
    ST_SHIFT_HI = 2'd3
  } joy_state_e;

  function automatic int frame_period(input int clk_div, input int num_bits, input int gap_ticks);
    return (1 + 2 * num_bits + gap_ticks) * clk_div;
  endfunction

endpackage

// File: rtl/joy_db9_serial_reader_if.sv
// Pin bundle between the serial reader (master) and the shift-register chain / core (slave).
// Pure wiring, no latency; ENABLE is the only flow control and is honoured between frames.
interface joy_db9_serial_reader_if #(
  parameter int NUM_BITS = 16
);
  logic                ENABLE;
  logic                JOY_CLK;
  logic                JOY_LOAD;
  logic                JOY_DATA;
  logic [NUM_BITS-1:0] JOY_OUT;
  logic                JOY_VALID;

  modport master (
    input  ENABLE,
    input  JOY_DATA,
    output JOY_CLK,
    output JOY_LOAD,
    output JOY_OUT,
    output JOY_VALID
  );

  modport slave (
    output ENABLE,
    output JOY_DATA,
    input  JOY_CLK,
    input  JOY_LOAD,
    input  JOY_OUT,
    input  JOY_VALID
  );
endinterface

// File: rtl/joy_tick_gen.sv
// Free-running divider: tick_o is high for one CLK_50 cycle out of every CLK_DIV.
// Tick is decoded from the counter register, so it is stable for the whole cycle.
module joy_tick_gen #(
  parameter int CLK_DIV = 8
) (
  input  logic CLK_50,
  input  logic RESET_N,
  output logic tick_o
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == CW'(CLK_DIV - 1));

  always_comb begin
    cnt_d = tick_o ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge CLK_50 or negedge RESET_N) begin
    if (!RESET_N) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
endmodule

// File: rtl/joy_db9_serial_reader.sv
// Polls a 74HC165-style chain: load pulse, NUM_BITS clocked reads, then an idle gap; commits the
// inverted word with a one-cycle JOY_VALID. No backpressure; ENABLE only gates the next frame.
module joy_db9_serial_reader
  import joy_serial_pkg::*;
#(
  parameter int CLK_DIV   = DEF_CLK_DIV,
  parameter int NUM_BITS  = DEF_NUM_BITS,
  parameter int GAP_TICKS = DEF_GAP_TICKS
) (
  input  logic                      CLK_50,
  input  logic                      RESET_N,
  joy_db9_serial_reader_if.master   bus
);
  localparam logic [1:0] S_GAP      = ST_GAP;
  localparam logic [1:0] S_LOAD     = ST_LOAD;
  localparam logic [1:0] S_SHIFT_LO = ST_SHIFT_LO;
  localparam logic [1:0] S_SHIFT_HI = ST_SHIFT_HI;

  localparam int GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam int BW = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;

  logic                tick;
  logic [1:0]          sync_q;
  logic [1:0]          state_q, state_d;
  logic [GW-1:0]       gap_q, gap_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic [NUM_BITS-1:0] sr_q, sr_d;
  logic [NUM_BITS-1:0] out_q, out_d;
  logic                vld_q, vld_d;
  logic                clk_q, clk_d;
  logic                load_q, load_d;

  joy_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .CLK_50  (CLK_50),
    .RESET_N (RESET_N),
    .tick_o  (tick)
  );

  // JOY_CLK/JOY_LOAD are registered alongside the state so each level spans a full tick period.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    bit_d   = bit_q;
    sr_d    = sr_q;
    out_d   = out_q;
    vld_d   = 1'b0;
    clk_d   = clk_q;
    load_d  = load_q;
    if (tick) begin
      case (state_q)
        S_GAP: begin
          if (gap_q == GW'(GAP_TICKS - 1)) begin
            if (bus.ENABLE) begin
              state_d = S_LOAD;
              gap_d   = '0;
              load_d  = 1'b0;
            end
          end else begin
            gap_d = gap_q + GW'(1);
          end
        end
        S_LOAD: begin
          state_d = S_SHIFT_LO;
          bit_d   = '0;
          load_d  = 1'b1;
        end
        S_SHIFT_LO: begin
          sr_d    = {sr_q[NUM_BITS-2:0], sync_q[1]};
          state_d = S_SHIFT_HI;
          clk_d   = 1'b1;
        end
        default: begin
          clk_d  = 1'b0;
          load_d = 1'b1;
          if (bit_q == BW'(NUM_BITS - 1)) begin
            out_d   = ~sr_q;
            vld_d   = 1'b1;
            state_d = S_GAP;
          end else begin
            bit_d   = bit_q + BW'(1);
            state_d = S_SHIFT_LO;
          end
        end
      endcase
    end
  end

  always_ff @(posedge CLK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      sync_q  <= 2'b11;
      state_q <= S_GAP;
      gap_q   <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      out_q   <= '0;
      vld_q   <= 1'b0;
      clk_q   <= 1'b0;
      load_q  <= 1'b1;
    end else begin
      sync_q  <= {sync_q[0], bus.JOY_DATA};
      state_q <= state_d;
      gap_q   <= gap_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
      clk_q   <= clk_d;
      load_q  <= load_d;
    end
  end

  assign bus.JOY_CLK   = clk_q;
  assign bus.JOY_LOAD  = load_q;
  assign bus.JOY_OUT   = out_q;
  assign bus.JOY_VALID = vld_q;
endmodule

// File: tb/tb_joy_db9_serial_reader.sv
// Bench for joy_db9_serial_reader: a 74HC165 chain model feeds the reader, the expected word is
// the inverted parallel input captured at each load, and protocol rules are watched every cycle.
module tb_joy_db9_serial_reader;
  import joy_serial_pkg::*;

  localparam int CD        = 4;
  localparam int NB        = 16;
  localparam int GT        = 2;
  localparam int FRAME_CYC = (1 + 2 * NB + GT) * CD;
  localparam int BUDGET    = 3 * frame_period(CD, NB, GT);

  logic CLK_50  = 1'b0;
  logic RESET_N = 1'b1;
  always #5 CLK_50 = ~CLK_50;

  joy_db9_serial_reader_if #(.NUM_BITS(NB)) bus ();

  joy_db9_serial_reader #(.CLK_DIV(CD), .NUM_BITS(NB), .GAP_TICKS(GT)) dut (
    .CLK_50  (CLK_50),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // 74HC165 chain: asynchronous parallel load while LOAD is low, shift on JOY_CLK rise, QH out.
  logic [NB-1:0] par_in   = '1;
  logic [NB-1:0] chain_sr = '1;
  always @(posedge bus.JOY_CLK or negedge bus.JOY_LOAD) begin
    if (!bus.JOY_LOAD) chain_sr <= par_in;
    else               chain_sr <= {chain_sr[NB-2:0], 1'b1};
  end
  assign bus.JOY_DATA = chain_sr[NB-1];

  logic          prev_clk  = 1'b0;
  logic          prev_load = 1'b1;
  logic          prev_vld  = 1'b0;
  logic          prev_rst  = 1'b0;
  logic [NB-1:0] prev_out  = '0;
  logic [NB-1:0] mon_exp;
  logic [NB-1:0] exp_q[$];
  int            load_low  = 0;
  int            clk_rises = 0;

  always @(negedge CLK_50) begin
    n_cmp++;
    if (bus.JOY_CLK === 1'b1 && bus.JOY_LOAD === 1'b0) begin
      n_fail++;
      $display("FAIL proto_clk_and_load: JOY_CLK=%b JOY_LOAD=%b, never both active", bus.JOY_CLK, bus.JOY_LOAD);
    end
    if (!RESET_N) begin
      exp_q.delete();
      load_low = 0;
    end else begin
      if (!bus.JOY_LOAD) begin
        load_low++;
      end else if (load_low != 0) begin
        n_cmp++;
        if (load_low != CD) begin
          n_fail++;
          $display("FAIL load_width: JOY_LOAD low %0d cycles, required %0d", load_low, CD);
        end
        load_low = 0;
      end
      if (prev_load && !bus.JOY_LOAD) begin
        exp_q.push_back(~par_in);
        clk_rises = 0;
      end
      if (bus.JOY_CLK && !prev_clk) clk_rises++;
      if (bus.JOY_VALID) begin
        n_cmp++;
        if (clk_rises != NB) begin
          n_fail++;
          $display("FAIL clk_edges_per_frame: %0d JOY_CLK rises, required %0d", clk_rises, NB);
        end
        n_cmp++;
        if (prev_vld) begin
          n_fail++;
          $display("FAIL valid_width: JOY_VALID high 2+ cycles, required 1");
        end
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL model_word: JOY_VALID with JOY_OUT=%h but no frame was loaded", bus.JOY_OUT);
        end else begin
          mon_exp = exp_q.pop_front();
          if (bus.JOY_OUT !== mon_exp) begin
            n_fail++;
            $display("FAIL model_word: JOY_OUT=%h required %h", bus.JOY_OUT, mon_exp);
          end
        end
      end else if (prev_rst) begin
        n_cmp++;
        if (bus.JOY_OUT !== prev_out) begin
          n_fail++;
          $display("FAIL out_hold: JOY_OUT changed %h -> %h without JOY_VALID", prev_out, bus.JOY_OUT);
        end
      end
    end
    prev_clk  = bus.JOY_CLK;
    prev_load = bus.JOY_LOAD;
    prev_vld  = bus.JOY_VALID;
    prev_rst  = RESET_N;
    prev_out  = bus.JOY_OUT;
  end

  task automatic wait_valid(output int cyc, output bit ok);
    ok  = 1'b0;
    cyc = 0;
    for (int i = 1; i <= BUDGET; i++) begin
      @(negedge CLK_50);
      if (bus.JOY_VALID) begin
        cyc = i;
        ok  = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_load_fall(output int cyc, output bit ok);
    logic pl;
    pl  = bus.JOY_LOAD;
    ok  = 1'b0;
    cyc = 0;
    for (int i = 1; i <= BUDGET; i++) begin
      @(negedge CLK_50);
      if (pl && !bus.JOY_LOAD) begin
        cyc = i;
        ok  = 1'b1;
        break;
      end
      pl = bus.JOY_LOAD;
    end
  endtask

  task automatic wait_clk_rises(input int n, output bit ok);
    logic pc;
    int   seen;
    pc   = bus.JOY_CLK;
    seen = 0;
    ok   = 1'b0;
    for (int i = 1; i <= BUDGET; i++) begin
      @(negedge CLK_50);
      if (bus.JOY_CLK && !pc) seen++;
      pc = bus.JOY_CLK;
      if (seen == n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int cyc;
    bit ok;
    #1;
    bus.ENABLE = 1'b1;
    par_in     = 16'h5A3C;
    RESET_N    = 1'b0;
    repeat (3) @(negedge CLK_50);
    n_cmp++;
    if (bus.JOY_CLK !== 1'b0) begin n_fail++; $display("FAIL reset_clk: JOY_CLK=%b required 0", bus.JOY_CLK); end
    n_cmp++;
    if (bus.JOY_LOAD !== 1'b1) begin n_fail++; $display("FAIL reset_load: JOY_LOAD=%b required 1", bus.JOY_LOAD); end
    n_cmp++;
    if (bus.JOY_OUT !== 16'h0000) begin n_fail++; $display("FAIL reset_out: JOY_OUT=%h required 0000", bus.JOY_OUT); end
    n_cmp++;
    if (bus.JOY_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_valid: JOY_VALID=%b required 0", bus.JOY_VALID); end
    RESET_N = 1'b1;
    wait_load_fall(cyc, ok);
    n_cmp++;
    if (!ok || cyc != 2 * CD) begin
      n_fail++;
      $display("FAIL first_load_delay: ok=%0b after %0d cycles, required %0d", ok, cyc, 2 * CD);
    end
  endtask

  task automatic test_pattern();
    int cyc;
    bit ok;
    wait_valid(cyc, ok);
    n_cmp++;
    if (!ok || bus.JOY_OUT !== 16'hA5C3) begin
      n_fail++;
      $display("FAIL pattern_word: ok=%0b JOY_OUT=%h required A5C3", ok, bus.JOY_OUT);
    end
    @(negedge CLK_50);
    n_cmp++;
    if (bus.JOY_VALID !== 1'b0) begin n_fail++; $display("FAIL pattern_pulse: JOY_VALID=%b one cycle later, required 0", bus.JOY_VALID); end
    wait_valid(cyc, ok);
    n_cmp++;
    if (!ok || cyc + 1 != FRAME_CYC) begin
      n_fail++;
      $display("FAIL frame_period: ok=%0b spacing %0d cycles, required %0d", ok, cyc + 1, FRAME_CYC);
    end
    n_cmp++;
    if (bus.JOY_OUT !== 16'hA5C3) begin n_fail++; $display("FAIL pattern_repeat: JOY_OUT=%h required A5C3", bus.JOY_OUT); end
  endtask

  task automatic test_mid_frame_change();
    int            cyc;
    bit            ok;
    bit            changed;
    logic [NB-1:0] held;
    par_in = 16'hFFFF;
    wait_load_fall(cyc, ok);
    wait_clk_rises(3, ok);
    par_in  = 16'h0000;
    held    = bus.JOY_OUT;
    changed = 1'b0;
    ok      = 1'b0;
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge CLK_50);
      if (bus.JOY_VALID) begin ok = 1'b1; break; end
      if (bus.JOY_OUT !== held) changed = 1'b1;
    end
    n_cmp++;
    if (changed) begin n_fail++; $display("FAIL midframe_hold: JOY_OUT=%h before commit, required %h", bus.JOY_OUT, held); end
    n_cmp++;
    if (!ok || bus.JOY_OUT !== 16'h0000) begin
      n_fail++;
      $display("FAIL midframe_commit: ok=%0b JOY_OUT=%h required 0000", ok, bus.JOY_OUT);
    end
    wait_valid(cyc, ok);
    n_cmp++;
    if (!ok || bus.JOY_OUT !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL midframe_next: ok=%0b JOY_OUT=%h required FFFF", ok, bus.JOY_OUT);
    end
  endtask

  task automatic test_enable_stop();
    int            cyc;
    bit            ok;
    int            loads;
    int            vlds;
    bit            moved;
    logic          pl;
    logic [NB-1:0] p;
    logic [NB-1:0] held;
    p      = NB'($urandom);
    par_in = p;
    wait_load_fall(cyc, ok);
    wait_clk_rises(6, ok);
    bus.ENABLE = 1'b0;
    wait_valid(cyc, ok);
    n_cmp++;
    if (!ok || bus.JOY_OUT !== ~p) begin
      n_fail++;
      $display("FAIL disable_commit: ok=%0b JOY_OUT=%h required %h", ok, bus.JOY_OUT, ~p);
    end
    held  = bus.JOY_OUT;
    loads = 0;
    vlds  = 0;
    moved = 1'b0;
    pl    = bus.JOY_LOAD;
    for (int i = 0; i < 1000; i++) begin
      @(negedge CLK_50);
      if (pl && !bus.JOY_LOAD) loads++;
      if (bus.JOY_VALID) vlds++;
      if (bus.JOY_OUT !== held) moved = 1'b1;
      pl = bus.JOY_LOAD;
    end
    n_cmp++;
    if (loads != 0) begin n_fail++; $display("FAIL disabled_loads: %0d JOY_LOAD falls, required 0", loads); end
    n_cmp++;
    if (vlds != 0) begin n_fail++; $display("FAIL disabled_valids: %0d JOY_VALID pulses, required 0", vlds); end
    n_cmp++;
    if (moved) begin n_fail++; $display("FAIL disabled_hold: JOY_OUT=%h required %h", bus.JOY_OUT, held); end
    p          = NB'($urandom);
    par_in     = p;
    bus.ENABLE = 1'b1;
    wait_load_fall(cyc, ok);
    n_cmp++;
    if (!ok || cyc < 1 || cyc > CD) begin
      n_fail++;
      $display("FAIL reenable_load: ok=%0b JOY_LOAD fell after %0d cycles, required 1..%0d", ok, cyc, CD);
    end
    wait_valid(cyc, ok);
    n_cmp++;
    if (!ok || bus.JOY_OUT !== ~p) begin
      n_fail++;
      $display("FAIL reenable_word: ok=%0b JOY_OUT=%h required %h", ok, bus.JOY_OUT, ~p);
    end
  endtask

  task automatic test_reset_mid_frame();
    int            cyc;
    bit            ok;
    int            vlds;
    logic [NB-1:0] p;
    par_in = NB'($urandom);
    wait_load_fall(cyc, ok);
    wait_clk_rises(10, ok);
    RESET_N = 1'b0;
    #1;
    n_cmp++;
    if (bus.JOY_CLK !== 1'b0) begin n_fail++; $display("FAIL midreset_clk: JOY_CLK=%b required 0", bus.JOY_CLK); end
    n_cmp++;
    if (bus.JOY_LOAD !== 1'b1) begin n_fail++; $display("FAIL midreset_load: JOY_LOAD=%b required 1", bus.JOY_LOAD); end
    n_cmp++;
    if (bus.JOY_OUT !== 16'h0000) begin n_fail++; $display("FAIL midreset_out: JOY_OUT=%h required 0000", bus.JOY_OUT); end
    vlds = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK_50);
      if (bus.JOY_VALID) vlds++;
    end
    n_cmp++;
    if (vlds != 0) begin n_fail++; $display("FAIL midreset_valid: %0d JOY_VALID pulses in reset, required 0", vlds); end
    p       = NB'($urandom);
    par_in  = p;
    RESET_N = 1'b1;
    wait_valid(cyc, ok);
    n_cmp++;
    if (!ok || cyc != FRAME_CYC || bus.JOY_OUT !== ~p) begin
      n_fail++;
      $display("FAIL midreset_recover: ok=%0b after %0d cycles JOY_OUT=%h, required %0d cycles and %h", ok, cyc, bus.JOY_OUT, FRAME_CYC, ~p);
    end
  endtask

  task automatic test_back_to_back();
    int            cyc;
    bit            ok;
    logic [NB-1:0] p;
    for (int f = 0; f < 8; f++) begin
      p      = NB'($urandom);
      par_in = p;
      wait_valid(cyc, ok);
      n_cmp++;
      if (!ok || bus.JOY_OUT !== ~p) begin
        n_fail++;
        $display("FAIL random_word[%0d]: ok=%0b JOY_OUT=%h required %h", f, ok, bus.JOY_OUT, ~p);
      end
      n_cmp++;
      if (cyc != FRAME_CYC) begin
        n_fail++;
        $display("FAIL random_period[%0d]: spacing %0d cycles, required %0d", f, cyc, FRAME_CYC);
      end
    end
  endtask

  initial begin
    bus.ENABLE = 1'b0;
    test_reset();
    test_pattern();
    test_mid_frame_change();
    test_enable_stop();
    test_reset_mid_frame();
    test_back_to_back();
    repeat (4) @(negedge CLK_50);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
